// File: rtl/csr_counters.sv
`default_nettype none
// ============================================================================
// csr_counters : RISC-V cycle/instret/mhpmcounter CSR block with inhibit mask
// Optional HPM counters enabled by define CSR_COUNTERS_HPM_EN.   Rev 1.0
// ============================================================================
module csr_counters #(
    parameter int XLEN      = 32,
    parameter int CNT_WIDTH = 64,
    parameter int NUM_HPM   = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  retire_i,
    input  logic [(NUM_HPM > 0 ? NUM_HPM : 1)-1:0] event_i,
    input  logic                                  csr_en_i,
    input  logic                                  csr_we_i,
    input  logic [11:0]                           csr_addr_i,
    input  logic [XLEN-1:0]                       csr_wdata_i,
    output logic                                  csr_rvalid_o,
    output logic [XLEN-1:0]                       csr_rdata_o,
    output logic                                  csr_illegal_o
);

`ifdef CSR_COUNTERS_HPM_EN
    localparam int HPM_N = NUM_HPM;
`else
    localparam int HPM_N = 0;
`endif
    // Slot 0 = cycle, slot 1 = instret, slot 2+k = hpm k (CSR index 3+k)
    localparam int          NUM_SLOT = 2 + HPM_N;
    localparam bit          HIGH_EN  = (XLEN == 32) && (CNT_WIDTH > 32);
    localparam logic [31:0] HPM_MASK = 32'((64'd1 << HPM_N) - 64'd1);
    localparam logic [31:0] INH_MASK = (HPM_MASK << 3) | 32'h0000_0005;

    logic [CNT_WIDTH-1:0] r_cnt      [NUM_SLOT];
    logic [CNT_WIDTH-1:0] w_cnt_next [NUM_SLOT];
    logic [31:0]          r_inh;
    logic                 r_rvalid;
    logic                 r_illegal;
    logic [XLEN-1:0]      r_rdata;

    logic [4:0]           w_idx;
    logic                 w_hi, w_user, w_mach, w_is_inh, w_idx_ok, w_is_cnt, w_illegal;
    logic [NUM_SLOT-1:0]  w_inc, w_inh, w_hit;
    logic [CNT_WIDTH-1:0] w_sel;
    logic [63:0]          w_old64, w_wd64, w_new64;
    logic [XLEN-1:0]      w_rdata;
    logic                 w_cnt_we, w_inh_we;
    logic                 w_unused_evt;

    always_comb begin
        w_idx     = csr_addr_i[4:0];
        w_hi      = csr_addr_i[7];
        w_user    = (csr_addr_i[11:8] == 4'hC) && (csr_addr_i[6:5] == 2'b00);
        w_mach    = (csr_addr_i[11:8] == 4'hB) && (csr_addr_i[6:5] == 2'b00);
        w_is_inh  = (csr_addr_i == 12'h320);
        w_idx_ok  = (w_idx == 5'd0) || (w_idx == 5'd2) ||
                    ((w_idx >= 5'd3) && (32'(w_idx) < 32'(3 + HPM_N)));
        w_is_cnt  = (w_user || w_mach) && w_idx_ok && (!w_hi || HIGH_EN);
        w_illegal = !(w_is_inh || (w_is_cnt && !(csr_we_i && w_user)));
        w_cnt_we  = csr_en_i && csr_we_i && !w_illegal && !w_is_inh;
        w_inh_we  = csr_en_i && csr_we_i && w_is_inh;
    end

    if (HPM_N > 0) begin : g_hpm
        assign w_inc        = {event_i[HPM_N-1:0], retire_i, 1'b1};
        assign w_inh        = {r_inh[3 +: HPM_N], r_inh[2], r_inh[0]};
        assign w_unused_evt = 1'b0;
    end else begin : g_no_hpm
        assign w_inc        = {retire_i, 1'b1};
        assign w_inh        = {r_inh[2], r_inh[0]};
        assign w_unused_evt = ^event_i;
    end

    always_comb begin
        w_sel = '0;
        w_hit = '0;
        for (int s = 0; s < NUM_SLOT; s++) begin
            w_hit[s] = (w_idx == 5'((s == 0) ? 0 : s + 1));
            if (w_hit[s]) w_sel = r_cnt[s];
        end
    end

    // Half writes merge with the untouched half of the selected counter
    always_comb begin
        w_old64 = 64'(w_sel);
        w_wd64  = 64'(csr_wdata_i);
        if (w_hi)
            w_new64 = {w_wd64[31:0], w_old64[31:0]};
        else if (XLEN == 32)
            w_new64 = {w_old64[63:32], w_wd64[31:0]};
        else
            w_new64 = w_wd64;

        if (w_is_inh)
            w_rdata = XLEN'(r_inh);
        else if (w_hi)
            w_rdata = XLEN'(w_old64 >> 32);
        else
            w_rdata = XLEN'(w_old64);
    end

    always_comb begin
        for (int s = 0; s < NUM_SLOT; s++) begin
            if (w_cnt_we && w_hit[s])
                w_cnt_next[s] = CNT_WIDTH'(w_new64);
            else
                w_cnt_next[s] = r_cnt[s] + CNT_WIDTH'(w_inc[s] && !w_inh[s]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SLOT; s++) r_cnt[s] <= '0;
        end else begin
            for (int s = 0; s < NUM_SLOT; s++) r_cnt[s] <= w_cnt_next[s];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_inh <= '0;
        else if (w_inh_we)
            r_inh <= csr_wdata_i[31:0] & INH_MASK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid  <= 1'b0;
            r_illegal <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_rvalid  <= csr_en_i;
            r_illegal <= csr_en_i && w_illegal;
            r_rdata   <= (csr_en_i && !w_illegal) ? w_rdata : '0;
        end
    end

    assign csr_rvalid_o  = r_rvalid;
    assign csr_illegal_o = r_illegal;
    assign csr_rdata_o   = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_csr_counters.sv
`default_nettype none
// ============================================================================
// tb_csr_counters : directed self-checking bench for csr_counters (defaults)
// Rev 1.0
// ============================================================================
module tb_csr_counters;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        retire_i;
    logic [3:0]  event_i;
    logic        csr_en_i;
    logic        csr_we_i;
    logic [11:0] csr_addr_i;
    logic [31:0] csr_wdata_i;
    logic        csr_rvalid_o;
    logic [31:0] csr_rdata_o;
    logic        csr_illegal_o;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] rd;
    logic        ill;
    logic        rv;

    csr_counters #(.XLEN(32), .CNT_WIDTH(64), .NUM_HPM(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .retire_i     (retire_i),
        .event_i      (event_i),
        .csr_en_i     (csr_en_i),
        .csr_we_i     (csr_we_i),
        .csr_addr_i   (csr_addr_i),
        .csr_wdata_i  (csr_wdata_i),
        .csr_rvalid_o (csr_rvalid_o),
        .csr_rdata_o  (csr_rdata_o),
        .csr_illegal_o(csr_illegal_o)
    );

    always #5 clk = ~clk;

    // Drive one access at a negedge, capture its response at the next negedge
    task automatic access(input logic we, input logic [11:0] addr, input logic [31:0] wd);
        csr_en_i    = 1'b1;
        csr_we_i    = we;
        csr_addr_i  = addr;
        csr_wdata_i = wd;
        @(negedge clk);
        rd  = csr_rdata_o;
        ill = csr_illegal_o;
        rv  = csr_rvalid_o;
        csr_en_i = 1'b0;
        csr_we_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (csr_rvalid_o !== 1'b0) $display("FAIL reset_rvalid: got %0h expected 0", csr_rvalid_o); else n_pass++;
        n_checks++; if (csr_rdata_o !== 32'd0) $display("FAIL reset_rdata: got %0h expected 0", csr_rdata_o); else n_pass++;
        n_checks++; if (csr_illegal_o !== 1'b0) $display("FAIL reset_illegal: got %0h expected 0", csr_illegal_o); else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_cycle;
        repeat (10) @(negedge clk);
        access(1'b0, 12'hC00, 32'd0);
        n_checks++; if (rv !== 1'b1) $display("FAIL cycle_rvalid: got %0h expected 1", rv); else n_pass++;
        n_checks++; if (rd !== 32'd10) $display("FAIL cycle_rdata: got %0h expected a", rd); else n_pass++;
        n_checks++; if (ill !== 1'b0) $display("FAIL cycle_illegal: got %0h expected 0", ill); else n_pass++;
        @(negedge clk);
        n_checks++; if (csr_rvalid_o !== 1'b0) $display("FAIL idle_rvalid: got %0h expected 0", csr_rvalid_o); else n_pass++;
        n_checks++; if (csr_rdata_o !== 32'd0) $display("FAIL idle_rdata: got %0h expected 0", csr_rdata_o); else n_pass++;
    endtask

    task automatic test_carry;
        access(1'b1, 12'hB00, 32'hFFFF_FFFF);
        n_checks++; if (rd !== 32'd12) $display("FAIL write_old_value: got %0h expected c", rd); else n_pass++;
        access(1'b1, 12'hB80, 32'd0);
        @(negedge clk);
        access(1'b0, 12'hC80, 32'd0);
        n_checks++; if (rd !== 32'd1) $display("FAIL carry_high: got %0h expected 1", rd); else n_pass++;
        access(1'b0, 12'hC00, 32'd0);
        n_checks++; if (rd !== 32'd1) $display("FAIL carry_low: got %0h expected 1", rd); else n_pass++;
    endtask

    task automatic test_illegal;
        access(1'b1, 12'hC00, 32'd0);
        n_checks++; if (ill !== 1'b1) $display("FAIL wr_user_illegal: got %0h expected 1", ill); else n_pass++;
        n_checks++; if (rd !== 32'd0) $display("FAIL wr_user_rdata: got %0h expected 0", rd); else n_pass++;
        n_checks++; if (rv !== 1'b1) $display("FAIL wr_user_rvalid: got %0h expected 1", rv); else n_pass++;
        access(1'b0, 12'hC00, 32'd0);
        n_checks++; if (rd !== 32'd3) $display("FAIL wr_user_nochange: got %0h expected 3", rd); else n_pass++;
        access(1'b0, 12'hC01, 32'd0);
        n_checks++; if (ill !== 1'b1) $display("FAIL time_illegal: got %0h expected 1", ill); else n_pass++;
        n_checks++; if (rd !== 32'd0) $display("FAIL time_rdata: got %0h expected 0", rd); else n_pass++;
        access(1'b0, 12'hC20, 32'd0);
        n_checks++; if (ill !== 1'b1) $display("FAIL unmapped_c20: got %0h expected 1", ill); else n_pass++;
        access(1'b0, 12'h321, 32'd0);
        n_checks++; if (ill !== 1'b1) $display("FAIL unmapped_321: got %0h expected 1", ill); else n_pass++;
    endtask

    task automatic test_inhibit;
        logic [31:0] exp_mask;
`ifdef CSR_COUNTERS_HPM_EN
        exp_mask = 32'h0000_007D;
`else
        exp_mask = 32'h0000_0005;
`endif
        access(1'b1, 12'h320, 32'h4);
        access(1'b0, 12'h320, 32'd0);
        n_checks++; if (rd !== 32'h4) $display("FAIL inhibit_read: got %0h expected 4", rd); else n_pass++;
        retire_i = 1'b1;
        repeat (5) @(negedge clk);
        retire_i = 1'b0;
        access(1'b0, 12'hC02, 32'd0);
        n_checks++; if (rd !== 32'd0) $display("FAIL instret_inhibited: got %0h expected 0", rd); else n_pass++;
        access(1'b1, 12'h320, 32'd0);
        retire_i = 1'b1;
        repeat (3) @(negedge clk);
        retire_i = 1'b0;
        access(1'b0, 12'hC02, 32'd0);
        n_checks++; if (rd !== 32'd3) $display("FAIL instret_count: got %0h expected 3", rd); else n_pass++;
        access(1'b1, 12'h320, 32'hFFFF_FFFF);
        access(1'b0, 12'h320, 32'd0);
        n_checks++; if (rd !== exp_mask) $display("FAIL inhibit_mask: got %0h expected %0h", rd, exp_mask); else n_pass++;
        access(1'b1, 12'hB00, 32'd50);
        repeat (2) @(negedge clk);
        access(1'b0, 12'hC00, 32'd0);
        n_checks++; if (rd !== 32'd50) $display("FAIL cycle_inhibited: got %0h expected 32", rd); else n_pass++;
        access(1'b1, 12'h320, 32'd0);
    endtask

    task automatic test_hpm;
`ifdef CSR_COUNTERS_HPM_EN
        event_i = 4'b0010;
        repeat (7) @(negedge clk);
        event_i = 4'b0000;
        access(1'b0, 12'hC04, 32'd0);
        n_checks++; if (rd !== 32'd7) $display("FAIL hpm1_count: got %0h expected 7", rd); else n_pass++;
        n_checks++; if (ill !== 1'b0) $display("FAIL hpm1_illegal: got %0h expected 0", ill); else n_pass++;
        access(1'b0, 12'hC03, 32'd0);
        n_checks++; if (rd !== 32'd0) $display("FAIL hpm0_count: got %0h expected 0", rd); else n_pass++;
        access(1'b0, 12'hC07, 32'd0);
        n_checks++; if (ill !== 1'b1) $display("FAIL hpm_oob_illegal: got %0h expected 1", ill); else n_pass++;
`else
        event_i = 4'b0010;
        repeat (7) @(negedge clk);
        event_i = 4'b0000;
        access(1'b0, 12'hC04, 32'd0);
        n_checks++; if (ill !== 1'b1) $display("FAIL hpm_disabled_illegal: got %0h expected 1", ill); else n_pass++;
        n_checks++; if (rd !== 32'd0) $display("FAIL hpm_disabled_rdata: got %0h expected 0", rd); else n_pass++;
        access(1'b0, 12'hB03, 32'd0);
        n_checks++; if (ill !== 1'b1) $display("FAIL hpm_disabled_b03: got %0h expected 1", ill); else n_pass++;
`endif
    endtask

    task automatic test_write_vs_inc;
        retire_i = 1'b1;
        access(1'b1, 12'hB02, 32'd100);
        retire_i = 1'b0;
        n_checks++; if (rd !== 32'd3) $display("FAIL wvi_old_value: got %0h expected 3", rd); else n_pass++;
        access(1'b0, 12'hC02, 32'd0);
        n_checks++; if (rd !== 32'd100) $display("FAIL wvi_instret: got %0h expected 64", rd); else n_pass++;
    endtask

    task automatic test_reset_mid;
        csr_en_i   = 1'b1;
        csr_we_i   = 1'b0;
        csr_addr_i = 12'hC02;
        #2 rst_n = 1'b0;
        csr_en_i = 1'b0;
        @(negedge clk);
        n_checks++; if (csr_rvalid_o !== 1'b0) $display("FAIL midrst_rvalid: got %0h expected 0", csr_rvalid_o); else n_pass++;
        n_checks++; if (csr_rdata_o !== 32'd0) $display("FAIL midrst_rdata: got %0h expected 0", csr_rdata_o); else n_pass++;
        rst_n = 1'b1;
        access(1'b0, 12'hC02, 32'd0);
        n_checks++; if (rd !== 32'd0) $display("FAIL midrst_instret: got %0h expected 0", rd); else n_pass++;
        access(1'b0, 12'hC00, 32'd0);
        n_checks++; if (rd !== 32'd1) $display("FAIL midrst_cycle: got %0h expected 1", rd); else n_pass++;
    endtask

    initial begin
        rst_n       = 1'b0;
        retire_i    = 1'b0;
        event_i     = 4'b0000;
        csr_en_i    = 1'b0;
        csr_we_i    = 1'b0;
        csr_addr_i  = 12'h000;
        csr_wdata_i = 32'd0;
        test_reset();
        test_cycle();
        test_carry();
        test_illegal();
        test_inhibit();
        test_hpm();
        test_write_vs_inc();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
